switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Upstream conditioning stage for the ZedBoard adder datapath.
- Takes the raw, asynchronous, bouncing 8 slide-switch inputs and synchronizes each bit to clk.
- Debounces each bit independently with a per-bit stability counter.
- Presents a clean, registered operand vector that feeds the adder's SWITCH input, plus a one-cycle change strobe for downstream capture logic.

Parameters:
- WIDTH, 8, number of switch bits conditioned.
- SYNC_STAGES, 2, flops in each bit's synchronizer chain; legal range 2..4.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronized bit must differ from its stable value before the stable value updates (10 ms at 100 MHz); legal minimum 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw_raw  in  WIDTH  raw switch pins; asynchronous to clk.
- sw_stable  out  WIDTH  debounced switch value; registered; drives the adder operand input.
- sw_changed  out  1  one-cycle pulse on the cycle sw_stable updates.
- changed_mask  out  WIDTH  bits of sw_stable that updated this cycle; valid only while sw_changed=1, else 0.
- glitch_count  out  16  aborted-bounce count (see Optional Feature).

Behaviour:
- Reset:
  - rst_n low asynchronously clears all synchronizer flops, counters, sw_stable, sw_changed, changed_mask and glitch_count to 0.
  - Release is synchronous to the next rising clk edge.
  - Reset mid-count discards the partial count; no pulse is generated.
- Synchronizer: sw_raw[i] passes through SYNC_STAGES flops. sync[i] is the last flop output. No logic is placed between synchronizer flops.
- Per-bit counter:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - Each rising edge, for each bit i:
    - If sync[i] == sw_stable[i]: cnt[i] <= 0.
    - Else if cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= sync[i]; cnt[i] <= 0; changed_mask[i] <= 1.
    - Else: cnt[i] <= cnt[i]+1.
- Pulse: sw_changed <= |(next changed_mask). Both sw_changed and changed_mask are registered and deassert the following cycle unless another bit completes.
- Latency:
  - Number rising edges E1, E2, ... starting from the first edge at which sw_raw[i] carries the new value.
  - sync[i] reflects the new value after E(SYNC_STAGES).
  - sw_stable[i] updates at E(SYNC_STAGES+DEBOUNCE_CYCLES), with sw_changed high for exactly the following cycle.
- Bounce: any cycle with sync[i] == sw_stable[i] before completion restarts that bit's count from 0.
- Simultaneous changes: bits that complete on the same edge produce a single sw_changed pulse, with all those bits set in changed_mask.
- Independence: the counter for one bit never affects another bit's counter.
- Back-to-back toggles: a bit that just updated may begin a new count on the next edge if sync differs again.
- No other outputs change while counts are in progress.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_COUNT_EN.
- Defined:
  - glitch_count increments by 1 on each edge where at least one bit has cnt[i] != 0 and sync[i] == sw_stable[i], meaning a bounce aborted a count.
  - Multiple bits aborting on the same edge count once.
  - glitch_count saturates at 16'hFFFF and never wraps.
  - Cleared only by rst_n.
- Undefined: glitch_count is tied to 16'h0000, and no counter logic is instantiated.

Test Plan (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: rst_n=0 with sw_raw=8'hFF -> sw_stable=8'h00, sw_changed=0, glitch_count=0 immediately, with no clk edge required.
- Clean step: after reset, sw_raw 8'h00->8'h05 held -> sw_stable=8'h05 after E6; sw_changed=1 for one cycle; changed_mask=8'h05.
- Bounce: sw_raw[0] toggles 1,0,1 on alternate cycles, then held at 1 -> no update until 4 consecutive synchronized mismatch cycles complete; exactly one pulse, changed_mask=8'h01; with DEBOUNCE_GLITCH_COUNT_EN, glitch_count ≥ 1.
- Staggered bits: bit 3 rises one cycle before bit 4 -> two separate pulses on consecutive cycles, masks 8'h08 then 8'h10; sw_stable ends at 8'h18.
- Reset mid-count: sw_raw=8'h80, then rst_n pulsed low at E4 -> sw_stable stays 8'h00 with no pulse; after release, sw_stable=8'h80 at E6 counted from the release edge.
- Saturation: with DEBOUNCE_GLITCH_COUNT_EN, force 65540 aborted bounces -> glitch_count=16'hFFFF, with no wrap.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes and debounces WIDTH slide switches with per-bit stability counters.
// Define DEBOUNCE_GLITCH_COUNT_EN to build the saturating aborted-bounce counter behind glitch_count.
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic [WIDTH-1:0] changed_mask,
    output logic [15:0]      glitch_count
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] done;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
        end else begin
            sync_ff[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
        end
    end

    assign sync   = sync_ff[SYNC_STAGES-1];
    assign differ = sync ^ sw_stable;

    always_comb begin
        done = '0;
        for (int b = 0; b < WIDTH; b++) done[b] = differ[b] && (cnt[b] == LAST);
    end

    // A matching cycle or a completed count both return the counter to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
        end else begin
            for (int b = 0; b < WIDTH; b++) cnt[b] <= (!differ[b] || done[b]) ? '0 : cnt[b] + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable    <= '0;
            changed_mask <= '0;
            sw_changed   <= 1'b0;
        end else begin
            sw_stable    <= sw_stable ^ done;
            changed_mask <= done;
            sw_changed   <= |done;
        end
    end

`ifdef DEBOUNCE_GLITCH_COUNT_EN
    logic [WIDTH-1:0] abort;

    always_comb begin
        abort = '0;
        for (int b = 0; b < WIDTH; b++) abort[b] = !differ[b] && (cnt[b] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_count <= 16'h0000;
        else if (|abort && glitch_count != 16'hFFFF) glitch_count <= glitch_count + 16'd1;
    end
`else
    assign glitch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed stimulus with a pulse scoreboard for switch_debouncer
// (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_switch_debouncer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_raw;
    logic [7:0] sw_stable;
    logic       sw_changed;
    logic [7:0] changed_mask;
    logic [15:0] glitch_count;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int k;

    typedef struct {
        int         at;
        logic [7:0] mask;
        logic [7:0] stab;
    } exp_t;
    exp_t q[$];

    switch_debouncer #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_changed(sw_changed),
        .changed_mask(changed_mask),
        .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [7:0] mask, input logic [7:0] stab);
        exp_t e;
        e.at = at;
        e.mask = mask;
        e.stab = stab;
        q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sw_changed === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got mask %0h stable %0h expected no pulse (cycle %0d)",
                         changed_mask, sw_stable, cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_mask", {24'h0, changed_mask}, {24'h0, e.mask});
                chk("pulse_stable", {24'h0, sw_stable}, {24'h0, e.stab});
            end
        end else begin
            chk("mask_idle", {24'h0, changed_mask}, 32'h0);
        end
    end

    initial begin
        rst_n  = 1'b1;
        sw_raw = 8'hFF;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_stable", {24'h0, sw_stable}, 32'h0);
        chk("reset_changed", {31'h0, sw_changed}, 32'h0);
        chk("reset_mask", {24'h0, changed_mask}, 32'h0);
        chk("reset_glitch", {16'h0, glitch_count}, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_hold_stable", {24'h0, sw_stable}, 32'h0);
        sw_raw = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_stable", {24'h0, sw_stable}, 32'h0);

        // clean step 00 -> 05
        sw_raw = 8'h05;
        k = cyc;
        expect_pulse(k + 6, 8'h05, 8'h05);
        repeat (5) @(negedge clk);
        chk("step_pre_update", {24'h0, sw_stable}, 32'h0);
        @(negedge clk);
        chk("step_updated", {24'h0, sw_stable}, 32'h05);
        @(negedge clk);
        chk("step_pulse_width", {31'h0, sw_changed}, 32'h0);
        repeat (4) @(negedge clk);

        // simultaneous release of two bits
        sw_raw = 8'h00;
        expect_pulse(cyc + 6, 8'h05, 8'h00);
        repeat (10) @(negedge clk);

        // bounce on bit 0: 1,0,1 then held
        sw_raw = 8'h01;
        k = cyc;
        @(negedge clk) sw_raw = 8'h00;
        @(negedge clk) sw_raw = 8'h01;
        expect_pulse(k + 8, 8'h01, 8'h01);
        repeat (5) @(negedge clk);
        chk("bounce_pre_update", {24'h0, sw_stable}, 32'h0);
        @(negedge clk);
        chk("bounce_updated", {24'h0, sw_stable}, 32'h01);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
        chk("bounce_glitch_seen", {31'h0, glitch_count != 16'h0}, 32'h1);
`else
        chk("glitch_tied_off", {16'h0, glitch_count}, 32'h0);
`endif
        repeat (4) @(negedge clk);
        sw_raw = 8'h00;
        expect_pulse(cyc + 6, 8'h01, 8'h00);
        repeat (10) @(negedge clk);

        // staggered bits 3 then 4
        sw_raw = 8'h08;
        k = cyc;
        expect_pulse(k + 6, 8'h08, 8'h08);
        @(negedge clk) sw_raw = 8'h18;
        expect_pulse(k + 7, 8'h10, 8'h18);
        repeat (10) @(negedge clk);
        chk("stagger_final", {24'h0, sw_stable}, 32'h18);

        // reset in the middle of a count
        sw_raw = 8'h80;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_stable", {24'h0, sw_stable}, 32'h0);
        chk("midreset_changed", {31'h0, sw_changed}, 32'h0);
        chk("midreset_glitch", {16'h0, glitch_count}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        k = cyc;
        expect_pulse(k + 6, 8'h80, 8'h80);
        repeat (5) @(negedge clk);
        chk("midreset_pre_update", {24'h0, sw_stable}, 32'h0);
        @(negedge clk);
        chk("midreset_updated", {24'h0, sw_stable}, 32'h80);
        repeat (4) @(negedge clk);

`ifdef DEBOUNCE_GLITCH_COUNT_EN
        // bits 0 and 1 bounce out of phase so one count aborts on every edge
        for (int n = 0; n < 65600; n++) begin
            @(negedge clk) sw_raw = n[0] ? 8'h81 : 8'h82;
        end
        sw_raw = 8'h80;
        repeat (10) @(negedge clk);
        chk("glitch_saturated", {16'h0, glitch_count}, 32'hFFFF);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk) sw_raw = n[0] ? 8'h81 : 8'h82;
        end
        sw_raw = 8'h80;
        repeat (10) @(negedge clk);
        chk("glitch_no_wrap", {16'h0, glitch_count}, 32'hFFFF);
`endif

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
